// File: rtl/mem_bus_unit.sv
// mem_bus_unit: sequences one four-T-state machine cycle (T1..T4) on the
// external memory bus for the CPU. The address and write byte come from the
// register file's read buses. The read byte is held on o_Data for write-back.
// Optional feature macro MEM_BUS_WAIT_EN adds i_Mem_Wait. While it is high,
// the machine cycle is stretched in T2.
module mem_bus_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              i_Clk,
    input  logic              i_nRst,
    input  logic              i_Enable,
    input  logic              i_Start,
    input  logic              i_Write,
    input  logic [ADDR_W-1:0] i_Addr,
    input  logic [DATA_W-1:0] i_Data,
    output logic              o_Busy,
    output logic              o_Done,
    output logic [DATA_W-1:0] o_Data,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [DATA_W-1:0] o_Mem_Dout,
    input  logic [DATA_W-1:0] i_Mem_Din,
`ifdef MEM_BUS_WAIT_EN
    input  logic              i_Mem_Wait,
`endif
    output logic              o_Mem_Rd,
    output logic              o_Mem_Wr
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic [DATA_W-1:0] rdata_q;

    // State register; the whole unit freezes while the tick qualifier is low
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state_q <= IDLE;
        end else if (i_Enable) begin
            state_q <= state_d;
        end
    end

    // Next state, request acceptance and bus strobes decoded from the current state only
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        o_Busy   = 1'b0;
        o_Done   = 1'b0;
        o_Mem_Rd = 1'b0;
        o_Mem_Wr = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_Start) begin
                    accept  = 1'b1;
                    state_d = T1;
                end
            end
            T1: begin
                o_Busy   = 1'b1;
                o_Mem_Rd = !write_q;
                state_d  = T2;
            end
            T2: begin
                o_Busy   = 1'b1;
                o_Mem_Rd = !write_q;
                o_Mem_Wr = write_q;
                state_d  = T3;
`ifdef MEM_BUS_WAIT_EN
                // A slow device stretches the cycle here while the strobes stay asserted
                if (i_Mem_Wait) begin
                    state_d = T2;
                end
`endif
            end
            T3: begin
                o_Busy   = 1'b1;
                o_Mem_Rd = !write_q;
                o_Mem_Wr = write_q;
                state_d  = T4;
            end
            T4: begin
                o_Busy = 1'b1;
                o_Done = 1'b1;
                // A new request in T4 chains straight into T1 with no idle gap
                if (i_Start) begin
                    accept  = 1'b1;
                    state_d = T1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the request at the accept edge so the register file may move on afterwards
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (i_Enable && accept) begin
            addr_q  <= i_Addr;
            wdata_q <= i_Data;
            write_q <= i_Write;
        end
    end

    // Read data is taken on the T3->T4 edge and held until the next read completes
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            rdata_q <= '0;
        end else if (i_Enable && (state_q == T3) && !write_q) begin
            rdata_q <= i_Mem_Din;
        end
    end

    assign o_Data     = rdata_q;
    assign o_Mem_Addr = addr_q;
    assign o_Mem_Dout = wdata_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Testbench for mem_bus_unit. It checks directed vectors, multi-cycle corner
// cases and random traffic against a transaction-level reference model.
module tb_mem_bus_unit;

`ifdef MEM_BUS_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic        wr_in = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  data = '0;
    logic [7:0]  din = '0;
    logic        mem_wait = 1'b0;

    logic        o_busy, o_done, o_rd, o_wr;
    logic [7:0]  o_data, o_dout;
    logic [15:0] o_maddr;

    int checks = 0;
    int failures = 0;

    // Reference model: position inside the current machine cycle (0 = no cycle)
    int          m_ph;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [7:0]  m_dout;
    logic [7:0]  m_data;

    typedef struct {
        logic        en, start, wr;
        logic [15:0] addr;
        logic [7:0]  data, din;
        logic        busy, done, rd, wrs;
        logic [15:0] maddr;
        logic [7:0]  dout, odata;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mem_bus_unit #(.ADDR_W(16), .DATA_W(8)) dut (
        .i_Clk(clk),
        .i_nRst(rst_n),
        .i_Enable(en),
        .i_Start(start),
        .i_Write(wr_in),
        .i_Addr(addr),
        .i_Data(data),
        .o_Busy(o_busy),
        .o_Done(o_done),
        .o_Data(o_data),
        .o_Mem_Addr(o_maddr),
        .o_Mem_Dout(o_dout),
        .i_Mem_Din(din),
`ifdef MEM_BUS_WAIT_EN
        .i_Mem_Wait(mem_wait),
`endif
        .o_Mem_Rd(o_rd),
        .o_Mem_Wr(o_wr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_wr = 1'b0; m_addr = '0; m_dout = '0; m_data = '0;
    endtask

    // One enabled edge of the model, evaluated from the inputs present before the edge
    task automatic model_edge();
        if (!en) return;
        if (m_ph == 3 && !m_wr) m_data = din;
        if ((m_ph == 0 || m_ph == 4) && start) begin
            m_ph = 1; m_wr = wr_in; m_addr = addr; m_dout = data;
        end else if (m_ph == 4) begin
            m_ph = 0;
        end else if (m_ph == 0) begin
            m_ph = 0;
        end else if (m_ph == 2 && WAIT_EN && mem_wait) begin
            m_ph = 2;
        end else begin
            m_ph = m_ph + 1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".busy"}, o_busy, m_ph != 0);
        chk({tag, ".done"}, o_done, m_ph == 4);
        chk({tag, ".rd"},   o_rd,   !m_wr && m_ph >= 1 && m_ph <= 3);
        chk({tag, ".wr"},   o_wr,   m_wr && m_ph >= 2 && m_ph <= 3);
        chk({tag, ".addr"}, o_maddr, m_addr);
        chk({tag, ".dout"}, o_dout, m_dout);
        chk({tag, ".data"}, o_data, m_data);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; en = 1'b1; mem_wait = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic add(input logic e, input logic s, input logic w, input logic [15:0] a,
                       input logic [7:0] d, input logic [7:0] di, input logic b, input logic dn,
                       input logic r, input logic ws, input logic [15:0] ma,
                       input logic [7:0] dt, input logic [7:0] od);
        vec_t v;
        v.en = e; v.start = s; v.wr = w; v.addr = a; v.data = d; v.din = di;
        v.busy = b; v.done = dn; v.rd = r; v.wrs = ws; v.maddr = ma; v.dout = dt; v.odata = od;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int rdcnt;
        vec_t v;

        // Reset and idle behaviour
        do_reset();
        check_model("rst");
        repeat (3) tick();
        check_model("idle");

        // Directed vectors: single read, single write, read then back-to-back write
        add(1,1,0,16'h0150,8'h00,8'h11, 1,0,1,0,16'h0150,8'h00,8'h00);
        add(1,0,0,16'hFFFF,8'h99,8'h11, 1,0,1,0,16'h0150,8'h00,8'h00);
        add(1,0,0,16'hFFFF,8'h99,8'h11, 1,0,1,0,16'h0150,8'h00,8'h00);
        add(1,0,0,16'hFFFF,8'h99,8'h3E, 1,1,0,0,16'h0150,8'h00,8'h3E);
        add(1,0,0,16'hFFFF,8'h99,8'h11, 0,0,0,0,16'h0150,8'h00,8'h3E);
        add(1,0,0,16'hFFFF,8'h99,8'h11, 0,0,0,0,16'h0150,8'h00,8'h3E);
        add(1,1,1,16'hC000,8'hA5,8'h11, 1,0,0,0,16'hC000,8'hA5,8'h3E);
        add(1,1,0,16'h1234,8'h00,8'h11, 1,0,0,1,16'hC000,8'hA5,8'h3E);
        add(1,1,0,16'h1234,8'h00,8'h11, 1,0,0,1,16'hC000,8'hA5,8'h3E);
        add(1,0,0,16'h1234,8'h00,8'h77, 1,1,0,0,16'hC000,8'hA5,8'h3E);
        add(1,1,0,16'h0100,8'h00,8'h11, 1,0,1,0,16'h0100,8'h00,8'h3E);
        add(1,0,1,16'h5555,8'h44,8'h11, 1,0,1,0,16'h0100,8'h00,8'h3E);
        add(1,0,1,16'h5555,8'h44,8'h11, 1,0,1,0,16'h0100,8'h00,8'h3E);
        add(1,0,1,16'h5555,8'h44,8'h5A, 1,1,0,0,16'h0100,8'h00,8'h5A);
        add(1,1,1,16'hFF80,8'h12,8'h11, 1,0,0,0,16'hFF80,8'h12,8'h5A);
        add(1,0,0,16'h0000,8'h00,8'h11, 1,0,0,1,16'hFF80,8'h12,8'h5A);
        add(1,0,0,16'h0000,8'h00,8'h11, 1,0,0,1,16'hFF80,8'h12,8'h5A);
        add(1,0,0,16'h0000,8'h00,8'h11, 1,1,0,0,16'hFF80,8'h12,8'h5A);
        add(1,0,0,16'h0000,8'h00,8'h11, 0,0,0,0,16'hFF80,8'h12,8'h5A);
        add(0,1,0,16'h0202,8'h33,8'h11, 0,0,0,0,16'hFF80,8'h12,8'h5A);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            en = v.en; start = v.start; wr_in = v.wr; addr = v.addr; data = v.data; din = v.din;
            tick();
            chk($sformatf("vec%0d.busy", i), o_busy, v.busy);
            chk($sformatf("vec%0d.done", i), o_done, v.done);
            chk($sformatf("vec%0d.rd", i),   o_rd,   v.rd);
            chk($sformatf("vec%0d.wr", i),   o_wr,   v.wrs);
            chk($sformatf("vec%0d.addr", i), o_maddr, v.maddr);
            chk($sformatf("vec%0d.dout", i), o_dout, v.dout);
            chk($sformatf("vec%0d.data", i), o_data, v.odata);
        end

        // Enable stall for three cycles in T2 of a read
        do_reset();
        en = 1; start = 1; wr_in = 0; addr = 16'h2222; din = 8'hC3;
        tick();
        start = 0;
        lat = 1;
        while (!o_done && lat < 20) begin
            en = (lat >= 2 && lat <= 4) ? 1'b0 : 1'b1;
            tick();
            lat++;
            if (!en) chk("stall.rd_held", o_rd, 1'b1);
            check_model("stall");
        end
        en = 1;
        chk("stall.latency", lat, 7);
        chk("stall.data", o_data, 8'hC3);

        // Asynchronous reset in T3 of a read abandons the cycle at once
        start = 1; addr = 16'h3333; din = 8'h5C;
        tick();
        start = 0;
        tick();
        tick();
        chk("arst.rd_before", o_rd, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst.rd", o_rd, 1'b0);
        chk("arst.busy", o_busy, 1'b0);
        chk("arst.data", o_data, 8'h00);
        chk("arst.addr", o_maddr, 16'h0000);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check_model("arst.after");

        // Two wait cycles in T2 of a read of 0x8000 (ignored without the wait feature)
        do_reset();
        start = 1; wr_in = 0; addr = 16'h8000; din = 8'h6B;
        tick();
        start = 0;
        lat = 1;
        rdcnt = o_rd ? 1 : 0;
        while (!o_done && lat < 20) begin
            mem_wait = (lat == 2 || lat == 3);
            tick();
            lat++;
            rdcnt += o_rd ? 1 : 0;
            check_model("wait");
        end
        mem_wait = 0;
        chk("wait.latency", lat, WAIT_EN ? 6 : 4);
        chk("wait.rd_cycles", rdcnt, WAIT_EN ? 5 : 3);
        chk("wait.data", o_data, 8'h6B);

        // Random traffic against the reference model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 7) != 0);
            start = ($urandom_range(0, 2) == 0);
            wr_in = $urandom_range(0, 1);
            addr = 16'($urandom);
            data = 8'($urandom);
            din = 8'($urandom);
            mem_wait = ($urandom_range(0, 2) == 0);
            tick();
            check_model("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
